// File: rtl/uart_pkg.sv
// Purpose: shared register map, bit indices, parity encodings and FSM state types for uart_fifo.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Word offsets from BASE_ADDR
    localparam logic [31:0] OFF_CSR    = 32'd0;
    localparam logic [31:0] OFF_BAUD   = 32'd1;
    localparam logic [31:0] OFF_TXDATA = 32'd2;
    localparam logic [31:0] OFF_RXDATA = 32'd3;
    localparam logic [31:0] OFF_STATUS = 32'd4;

    // CSR bit indices
    localparam int CSR_TX_EN     = 0;
    localparam int CSR_RX_EN     = 1;
    localparam int CSR_PAR_LO    = 2;
    localparam int CSR_PAR_HI    = 3;
    localparam int CSR_RX_IRQ_EN = 4;
    localparam int CSR_TX_IRQ_EN = 5;

    // STATUS bit indices; [7:4] are sticky and clear on read
    localparam int ST_TX_BUSY   = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_TX_OVF    = 4;
    localparam int ST_RX_OVR    = 5;
    localparam int ST_PAR_ERR   = 6;
    localparam int ST_FRAME_ERR = 7;

    // Parity modes in CSR[3:2]; 2'b11 behaves as none
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Divisors (BAUD register value) for a 50 MHz clock
    localparam logic [15:0] BAUD_9600   = 16'd5207;
    localparam logic [15:0] BAUD_19200  = 16'd2603;
    localparam logic [15:0] BAUD_38400  = 16'd1301;
    localparam logic [15:0] BAUD_57600  = 16'd867;
    localparam logic [15:0] BAUD_115200 = 16'd433;
    localparam logic [15:0] BAUD_MIN    = 16'd4;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Parity bit to transmit/expect; data is zero-extended so short words work too
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Purpose: single-clock FIFO used for the UART TX and RX queues.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
// Ports: push/din write side, pop read side, full/empty flags, head = oldest entry (undefined when empty).
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// Purpose: memory-mapped UART with TX/RX FIFOs, CSR/BAUD/STATUS registers and a level interrupt.
// Latency: read data one cycle after uart_read_enable; TX start bit one cycle after the FIFO pop.
// Backpressure: none on the bus; full TX FIFO drops writes (tx_ovf), full RX FIFO drops bytes (rx_ovr).
// Ports: clk/reset (async active-low), write/read word bus, uart_tx/uart_rx serial pins, uart_irq.
// Option: define UART_PARITY_EN to build parity generation/checking; otherwise CSR[3:2] read 0.
module uart_fifo
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'hb000_0000,
    parameter int          DATA_BITS      = 8,
    parameter int          TX_FIFO_DEPTH  = 16,
    parameter int          RX_FIFO_DEPTH  = 16,
    parameter int          STOP_BITS      = 1,
    parameter logic [15:0] BAUD_DIV_RESET = BAUD_115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] uart_write_address,
    input  logic [31:0] uart_write_data,
    input  logic        uart_write_enable,
    input  logic [31:0] uart_read_address,
    input  logic        uart_read_enable,
    output logic [31:0] uart_read_data,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        uart_irq
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    localparam logic [5:0] CSR_WMASK = 6'h3f;
`else
    localparam logic [5:0] CSR_WMASK = 6'h33;
`endif

    logic [5:0]  csr;
    logic [15:0] baud;
    logic        tx_ovf, rx_ovr, par_err, frame_err;
    logic        par_on, par_odd;

    logic wr_csr, wr_baud, wr_tx, rd_rx, st_clr;
    assign wr_csr  = uart_write_enable && (uart_write_address == BASE_ADDR + OFF_CSR);
    assign wr_baud = uart_write_enable && (uart_write_address == BASE_ADDR + OFF_BAUD);
    assign wr_tx   = uart_write_enable && (uart_write_address == BASE_ADDR + OFF_TXDATA);
    assign rd_rx   = uart_read_enable  && (uart_read_address  == BASE_ADDR + OFF_RXDATA);
    assign st_clr  = uart_read_enable  && (uart_read_address  == BASE_ADDR + OFF_STATUS);

    logic unused_wdata;
    assign unused_wdata = &{1'b0, uart_write_data[31:16]};

    assign par_on  = (csr[CSR_PAR_HI:CSR_PAR_LO] == PAR_EVEN) || (csr[CSR_PAR_HI:CSR_PAR_LO] == PAR_ODD);
    assign par_odd = (csr[CSR_PAR_HI:CSR_PAR_LO] == PAR_ODD);

    // FIFOs
    logic                 tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] tx_head, rx_head;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(wr_tx), .din(uart_write_data[DATA_BITS-1:0]),
        .pop(tx_pop), .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    assign rx_pop = rd_rx & ~rx_empty;

    // ---------------- TX FSM ----------------
    tx_state_t            tx_state, tx_state_nxt;
    logic [15:0]          tx_cnt, tx_cnt_nxt, tx_div, tx_div_nxt;
    logic [2:0]           tx_bit, tx_bit_nxt, tx_bit_inc;
    logic [DATA_BITS-1:0] tx_shreg, tx_shreg_nxt;
    logic                 tx_par, tx_par_nxt, tx_par_on, tx_par_on_nxt, tx_line_nxt;
    logic                 tx_bit_end, tx_load, tx_busy;

    assign tx_busy    = (tx_state != TX_IDLE);
    assign tx_bit_inc = tx_bit + 3'd1;

    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt + 16'd1;
        tx_div_nxt    = tx_div;
        tx_bit_nxt    = tx_bit;
        tx_shreg_nxt  = tx_shreg;
        tx_par_nxt    = tx_par;
        tx_par_on_nxt = tx_par_on;
        tx_line_nxt   = uart_tx;
        tx_pop        = 1'b0;
        tx_load       = 1'b0;
        tx_bit_end    = (tx_cnt == tx_div);
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt  = '0;
                tx_line_nxt = 1'b1;
                tx_load     = csr[CSR_TX_EN] & ~tx_empty;
            end
            TX_START: if (tx_bit_end) begin
                tx_state_nxt = TX_DATA;
                tx_cnt_nxt   = '0;
                tx_bit_nxt   = '0;
                tx_line_nxt  = tx_shreg[0];
            end
            TX_DATA: if (tx_bit_end) begin
                tx_cnt_nxt = '0;
                if (tx_bit == LAST_DATA) begin
                    tx_bit_nxt   = '0;
                    tx_state_nxt = tx_par_on ? TX_PARITY : TX_STOP;
                    tx_line_nxt  = tx_par_on ? tx_par : 1'b1;
                end else begin
                    tx_bit_nxt  = tx_bit_inc;
                    tx_line_nxt = tx_shreg[tx_bit_inc];
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = TX_STOP;
                tx_line_nxt  = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                tx_cnt_nxt = '0;
                if (tx_bit == LAST_STOP) begin
                    tx_state_nxt = TX_IDLE;
                    // chain straight into the next frame so back-to-back bytes have no idle gap
                    tx_load      = csr[CSR_TX_EN] & ~tx_empty;
                end else begin
                    tx_bit_nxt = tx_bit_inc;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_pop        = 1'b1;
            tx_state_nxt  = TX_START;
            tx_cnt_nxt    = '0;
            tx_bit_nxt    = '0;
            tx_div_nxt    = baud;
            tx_shreg_nxt  = tx_head;
            tx_par_on_nxt = par_on;
            tx_par_nxt    = parity_bit(8'(tx_head), par_odd);
            tx_line_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_div    <= BAUD_DIV_RESET;
            tx_bit    <= '0;
            tx_shreg  <= '0;
            tx_par    <= 1'b0;
            tx_par_on <= 1'b0;
            uart_tx   <= 1'b1;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_div    <= tx_div_nxt;
            tx_bit    <= tx_bit_nxt;
            tx_shreg  <= tx_shreg_nxt;
            tx_par    <= tx_par_nxt;
            tx_par_on <= tx_par_on_nxt;
            uart_tx   <= tx_line_nxt;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t            rx_state, rx_state_nxt;
    logic [15:0]          rx_cnt, rx_cnt_nxt, rx_div, rx_div_nxt;
    logic [2:0]           rx_bit, rx_bit_nxt;
    logic [DATA_BITS-1:0] rx_shreg, rx_shreg_nxt;
    logic                 rx_par_on, rx_par_on_nxt, rx_par_odd, rx_par_odd_nxt, rx_par_bad, rx_par_bad_nxt;
    logic                 rx_s1, rx_s2, rx_s3;
    logic                 frame_evt, par_evt, ovr_evt;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .din(rx_shreg),
        .pop(rx_pop), .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_cnt + 16'd1;
        rx_div_nxt     = rx_div;
        rx_bit_nxt     = rx_bit;
        rx_shreg_nxt   = rx_shreg;
        rx_par_on_nxt  = rx_par_on;
        rx_par_odd_nxt = rx_par_odd;
        rx_par_bad_nxt = rx_par_bad;
        rx_push        = 1'b0;
        frame_evt      = 1'b0;
        par_evt        = 1'b0;
        ovr_evt        = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (csr[CSR_RX_EN] && rx_s3 && !rx_s2) begin
                    rx_state_nxt   = RX_START;
                    rx_div_nxt     = baud;
                    rx_par_on_nxt  = par_on;
                    rx_par_odd_nxt = par_odd;
                    rx_par_bad_nxt = 1'b0;
                end
            end
            // Half-bit check of the start bit; every later sample is a full bit apart, i.e. mid-bit
            RX_START: if (rx_cnt == {1'b0, rx_div[15:1]}) begin
                rx_cnt_nxt   = '0;
                rx_bit_nxt   = '0;
                rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == rx_div) begin
                rx_cnt_nxt           = '0;
                rx_shreg_nxt[rx_bit] = rx_s2;
                if (rx_bit == LAST_DATA) begin
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_par_on ? RX_PARITY : RX_STOP;
                end else begin
                    rx_bit_nxt = rx_bit + 3'd1;
                end
            end
            RX_PARITY: if (rx_cnt == rx_div) begin
                rx_cnt_nxt     = '0;
                rx_par_bad_nxt = (rx_s2 != parity_bit(8'(rx_shreg), rx_par_odd));
                rx_state_nxt   = RX_STOP;
            end
            RX_STOP: if (rx_cnt == rx_div) begin
                rx_cnt_nxt   = '0;
                rx_state_nxt = RX_IDLE;
                if (!rx_s2) begin
                    frame_evt = 1'b1;
                end else if (rx_par_bad) begin
                    par_evt = 1'b1;
                end else begin
                    rx_push = 1'b1;
                    ovr_evt = rx_full & ~rx_pop;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_div     <= BAUD_DIV_RESET;
            rx_bit     <= '0;
            rx_shreg   <= '0;
            rx_par_on  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bad <= 1'b0;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
        end else begin
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_div     <= rx_div_nxt;
            rx_bit     <= rx_bit_nxt;
            rx_shreg   <= rx_shreg_nxt;
            rx_par_on  <= rx_par_on_nxt;
            rx_par_odd <= rx_par_odd_nxt;
            rx_par_bad <= rx_par_bad_nxt;
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
        end
    end

    // ---------------- Registers, read mux, interrupt ----------------
    logic [31:0] status, rd_mux;
    assign status = {24'b0, frame_err, par_err, rx_ovr, tx_ovf, rx_full, rx_empty, tx_full, tx_busy};

    always_comb begin
        rd_mux = '0;
        if (uart_read_address == BASE_ADDR + OFF_CSR)         rd_mux = {26'b0, csr};
        else if (uart_read_address == BASE_ADDR + OFF_BAUD)   rd_mux = {16'b0, baud};
        else if (uart_read_address == BASE_ADDR + OFF_RXDATA) rd_mux = rx_empty ? '0 : 32'(rx_head);
        else if (uart_read_address == BASE_ADDR + OFF_STATUS) rd_mux = status;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csr            <= '0;
            baud           <= BAUD_DIV_RESET;
            tx_ovf         <= 1'b0;
            rx_ovr         <= 1'b0;
            par_err        <= 1'b0;
            frame_err      <= 1'b0;
            uart_read_data <= '0;
            uart_irq       <= 1'b0;
        end else begin
            if (wr_csr)  csr  <= uart_write_data[5:0] & CSR_WMASK;
            if (wr_baud) baud <= (uart_write_data[15:0] < BAUD_MIN) ? BAUD_MIN : uart_write_data[15:0];
            // A new event in the clearing cycle wins over the clear
            tx_ovf    <= (tx_ovf    & ~st_clr) | (wr_tx & tx_full & ~tx_pop);
            rx_ovr    <= (rx_ovr    & ~st_clr) | ovr_evt;
            par_err   <= (par_err   & ~st_clr) | par_evt;
            frame_err <= (frame_err & ~st_clr) | frame_evt;
            if (uart_read_enable) uart_read_data <= rd_mux;
            uart_irq <= (csr[CSR_RX_IRQ_EN] & ~rx_empty)
                      | (csr[CSR_TX_IRQ_EN] & tx_empty & ~tx_busy)
                      | (csr[CSR_RX_IRQ_EN] & rx_ovr);
        end
    end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Memory-mapped UART successor to the single-buffer UART used by the SoC bootloader path.
- Adds parametrised TX/RX FIFOs, data width, stop bits and optional parity, plus a status register and an interrupt.
- Sits on the core data bus at BASE_ADDR. Its TX pin drives a peer's RX pin, as in the bootloader frame loader.

Parameters:
- BASE_ADDR, 32'hb000_0000, word address of CSR; BAUD = +1, TXDATA = +2, RXDATA = +3, STATUS = +4.
- DATA_BITS, 8, payload bits per frame, legal range 5..8.
- TX_FIFO_DEPTH, 16, TX FIFO entries, power of 2, at least 2.
- RX_FIFO_DEPTH, 16, RX FIFO entries, power of 2, at least 2.
- STOP_BITS, 1, stop bits transmitted (1 or 2); the receiver checks only the first.
- BAUD_DIV_RESET, 16'd433, reset divisor (115200 baud at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- uart_write_address  in  32  write word address.
- uart_write_data  in  32  write data.
- uart_write_enable  in  1  single-cycle write strobe.
- uart_read_address  in  32  read word address.
- uart_read_enable  in  1  read strobe; a read of RXDATA pops the RX FIFO.
- uart_read_data  out  32  registered read data.
- uart_tx  out  1  serial out, idle high.
- uart_rx  in  1  serial in, asynchronous.
- uart_irq  out  1  level interrupt.

Behaviour:
- Reset (reset=0, asynchronous):
  - CSR=0, BAUD=BAUD_DIV_RESET.
  - FIFOs empty, sticky flags cleared, FSMs IDLE.
  - uart_tx=1, uart_read_data=0, uart_irq=0.
  - Reset asserted mid-frame forces uart_tx high within the same cycle.
- CSR bits:
  - [0] tx_en, [1] rx_en.
  - [3:2] parity: 00 none, 01 even, 10 odd, 11 treated as none.
  - [4] rx_irq_en, [5] tx_irq_en. Other bits read 0.
- Bit timing: each bit lasts BAUD+1 clocks. Written BAUD values below 4 are clamped to 4. A BAUD write takes effect at the next frame start.
- Writes:
  - A write takes effect at the clock edge where uart_write_enable=1.
  - TXDATA push: write_data[DATA_BITS-1:0]. If the TX FIFO is full, the write is dropped and sticky tx_ovf is set.
  - Writes to RXDATA, STATUS or unmapped addresses are ignored.
- Reads:
  - Data is valid the cycle after uart_read_enable. Unmapped addresses return 0.
  - RXDATA read returns {0, head} and pops the head. When empty it returns 0 and does not pop.
  - STATUS = {24'b0, frame_err, par_err, rx_ovr, tx_ovf, rx_full, rx_empty, tx_full, tx_busy}.
  - A STATUS read clears bits [7:4] (sticky) in the same cycle the value is captured. An event arriving in that cycle stays set.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Leaves IDLE when tx_en=1 and the FIFO is not empty; pops the FIFO and drives the start bit from the next cycle.
  - Sends LSB first, then parity (when enabled), then STOP_BITS high bits.
  - Clearing tx_en mid-frame lets the current frame finish; no further pops.
  - tx_busy=1 whenever not in IDLE.
- RX path:
  - Two-flop synchroniser on uart_rx.
  - RX FSM: IDLE, START, DATA, PARITY, STOP.
  - Leaves IDLE on a falling edge when rx_en=1. Samples at the half-bit point; a high start sample returns to IDLE (glitch reject).
  - Data and stop bits are sampled mid-bit.
  - Stop bit low: set frame_err and discard the byte.
  - Parity mismatch: set par_err and discard the byte.
  - Valid byte with RX FIFO full: discard it and set rx_ovr.
- FIFOs: a simultaneous push and pop is legal at any fill level. When full, the pop completes and the push succeeds.
- Interrupt: uart_irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty & !tx_busy) | (rx_irq_en & rx_ovr). Registered, one cycle behind its sources.

Optional Feature:
- UART_PARITY_EN defined: parity logic is built as described.
- Undefined: CSR[3:2] read 0, no parity bit is sent or expected, and par_err is stuck at 0.

Decomposition:
- Package uart_pkg holds:
  - Register offsets (CSR, BAUD, TXDATA, RXDATA, STATUS).
  - CSR and STATUS bit indices.
  - Parity mode encodings.
  - The TX and RX state enums.
  - Baud constants for 50 MHz: 5207, 2603, 1301, 867, 433.
- Sub-module uart_sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, head) is instantiated for TX and RX.

Test Plan:
- Loopback, BAUD=433, CSR=0x13: write 0x01, 0x02, 0x03, 0x04 back-to-back -> peer RX receives the same bytes in order, with no idle gap longer than 1 bit.
- Write 17 bytes with tx_en=0, then set tx_en -> the 17th write is dropped, tx_ovf=1, exactly 16 frames leave, STATUS[4] clears after the read.
- Drive 17 RX frames without reading -> rx_full=1, rx_ovr=1, RXDATA yields the first 16 bytes, then 0 with rx_empty=1.
- UART_PARITY_EN defined, CSR[3:2]=01, send 0xA5 with odd parity from the bench -> byte discarded, par_err=1; 0x5A with correct parity -> received.
- Stop bit forced low on 0xF0 -> frame_err=1, RX FIFO unchanged; a 0.3-bit low glitch on an idle line -> no frame.
- Assert reset mid-TX of 0x0F -> uart_tx=1 immediately, STATUS=0x04 after release, BAUD reads 433.
